axi4_wresp_gen: RTL and testbench
=================================

AXI4_WRESP_GEN -- requirements
Module: axi4_wresp_gen

Interface
REQ-001 Parameter: ID_W, default 5, width of the AXI ID field.
REQ-002 Parameter: AW_DEPTH, default 4, depth of the accepted-address FIFO; SHALL be a power of two, 2 to 16.
REQ-003 Reset is `reset`, synchronous, active-high; the clock is `clk`.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 aw_valid / aw_ready  in / out  1 / 1  write-address handshake.
REQ-007 aw_id / aw_user / aw_len / aw_err  in  ID_W / 1 / 8 / 1  burst ID, user bit, beats-1, decode-error flag.
REQ-008 w_valid / w_ready / w_last  in / out / in  1 / 1 / 1  write-data handshake and last-beat flag; data payload is not routed through this block.
REQ-009 b_valid / b_ready  out / in  1 / 1  write-response handshake.
REQ-010 b_resp / b_id / b_user  out  2 / ID_W / 1  response code, ID, user bit.
REQ-011 outstanding  out  $clog2(AW_DEPTH)+1  number of bursts accepted on AW whose B has not yet completed its handshake.

Function
REQ-012 The block SHALL store {aw_id, aw_user, aw_len, aw_err} in a FIFO of AW_DEPTH entries on each AW handshake.
REQ-013 aw_ready SHALL equal !fifo_full; a pop in the same cycle SHALL NOT open aw_ready (no full-bypass).
REQ-014 w_ready SHALL equal !fifo_empty & (!b_valid | b_ready); there is no empty-bypass, so AW and W arriving in the same cycle into an empty FIFO SHALL accept only AW.
REQ-015 An 8-bit beat counter SHALL increment on each W handshake with w_last=0, saturating at 8'hFF, and SHALL clear to 0 on a W handshake with w_last=1.
REQ-016 On a W handshake with w_last=1, the block SHALL pop the FIFO head and load the B register on the same edge: b_id = head id, b_user = head user, b_resp = 2'b11 if head err, else 2'b10 if beat_cnt != head len, else 2'b00.
REQ-017 b_valid SHALL rise on the cycle after the last-beat handshake (latency 1) and SHALL hold with b_resp/b_id/b_user stable until b_ready.
REQ-018 If b_ready and a new last-beat handshake occur in the same cycle, the B register SHALL reload with the new response and b_valid SHALL stay 1.
REQ-019 Responses SHALL be issued in AW acceptance order.
REQ-020 outstanding SHALL be +1 on AW handshake, -1 on B handshake, and unchanged when both occur in the same cycle; it SHALL never exceed AW_DEPTH+1.
REQ-021 FIFO pointers SHALL wrap modulo AW_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or a count.

Reset
REQ-022 While reset=1: FIFO empty, beat_cnt=0, b_valid=0, b_resp=0, b_id=0, b_user=0, outstanding=0, aw_ready=0, w_ready=0.
REQ-023 On the first cycle after reset deasserts, aw_ready SHALL be 1.
REQ-024 Reset asserted mid-burst SHALL discard all stored bursts and partial beat counts; no B SHALL be issued for them.
REQ-025 FIFO storage contents need not be reset.

Verification
REQ-026 AW{id=5,len=3,err=0}, then 4 W beats with last on beat 4 -> one cycle later b_valid=1, b_id=5, b_resp=2'b00; outstanding goes 1 -> 0 after b_ready.
REQ-027 AW{id=2,len=3} with last on beat 2 -> b_resp=2'b10, b_id=2; a following burst with len=0 and last on beat 1 -> b_resp=2'b00.
REQ-028 AW{id=7,err=1,len=0} with one W beat carrying last -> b_resp=2'b11, b_id=7.
REQ-029 With b_ready=0, issue 4 AWs -> aw_ready=0 after the 4th; complete burst 1 -> b_valid held; w_ready=0 for burst 2 until b_ready=1; responses return in ID order.
REQ-030 With b_ready held 1, run back-to-back single-beat bursts -> b_valid stays 1 continuously and every ID appears exactly once.
REQ-031 Assert reset after 2 beats of a 4-beat burst -> b_valid=0, outstanding=0; a fresh burst then completes normally with b_resp=2'b00.

Source files
------------

// File: rtl/axi4_wresp_gen.sv
// AXI4 write-response generator: queues accepted AW bursts, counts W beats and
// issues one B response per burst, in AW acceptance order.
module axi4_wresp_gen #(
   parameter int unsigned ID_W     = 5,
   parameter int unsigned AW_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [ID_W-1:0]           aw_id,
   input  logic                      aw_user,
   input  logic [7:0]                aw_len,
   input  logic                      aw_err,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic                      w_last,
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic [1:0]                b_resp,
   output logic [ID_W-1:0]           b_id,
   output logic                      b_user,
   output logic [$clog2(AW_DEPTH):0] outstanding
);

   localparam int unsigned PTR_W = $clog2(AW_DEPTH);
   localparam int unsigned ENT_W = ID_W + 10;

   // Entry layout: {id, user, len[7:0], err}
   logic [ENT_W-1:0] mem [AW_DEPTH];

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;
   logic             b_valid_q, b_valid_d;
   logic [1:0]       b_resp_q, b_resp_d;
   logic [ID_W-1:0]  b_id_q, b_id_d;
   logic             b_user_q, b_user_d;
   logic [PTR_W:0]   outstanding_q, outstanding_d;

   logic             fifo_full, fifo_empty;
   logic             aw_hs, w_hs, last_hs, b_hs;
   logic [ENT_W-1:0] head;
   logic [ID_W-1:0]  head_id;
   logic             head_user;
   logic [7:0]       head_len;
   logic             head_err;

   // Extra MSB on the pointers separates full from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign aw_ready = !reset && !fifo_full;
   assign w_ready  = !reset && !fifo_empty && (!b_valid_q || b_ready);

   assign aw_hs   = aw_valid && aw_ready;
   assign w_hs    = w_valid && w_ready;
   assign last_hs = w_hs && w_last;
   assign b_hs    = b_valid_q && b_ready;

   assign head      = mem[rd_ptr_q[PTR_W-1:0]];
   assign head_err  = head[0];
   assign head_len  = head[8:1];
   assign head_user = head[9];
   assign head_id   = head[ENT_W-1:10];

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      b_valid_d     = b_valid_q;
      b_resp_d      = b_resp_q;
      b_id_d        = b_id_q;
      b_user_d      = b_user_q;
      outstanding_d = outstanding_q;

      if (aw_hs) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (last_hs) begin
         beat_cnt_d = 8'h00;
      end else if (w_hs && beat_cnt_q != 8'hFF) begin
         beat_cnt_d = beat_cnt_q + 8'h01;
      end

      // A last beat reloads B even while the old response is being taken.
      if (last_hs) begin
         rd_ptr_d  = rd_ptr_q + 1'b1;
         b_valid_d = 1'b1;
         b_id_d    = head_id;
         b_user_d  = head_user;
         if (head_err) begin
            b_resp_d = 2'b11;
         end else if (beat_cnt_q != head_len) begin
            b_resp_d = 2'b10;
         end else begin
            b_resp_d = 2'b00;
         end
      end else if (b_hs) begin
         b_valid_d = 1'b0;
      end

      if (aw_hs && !b_hs) begin
         outstanding_d = outstanding_q + 1'b1;
      end else if (b_hs && !aw_hs) begin
         outstanding_d = outstanding_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         beat_cnt_q    <= 8'h00;
         b_valid_q     <= 1'b0;
         b_resp_q      <= 2'b00;
         b_id_q        <= '0;
         b_user_q      <= 1'b0;
         outstanding_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         b_valid_q     <= b_valid_d;
         b_resp_q      <= b_resp_d;
         b_id_q        <= b_id_d;
         b_user_q      <= b_user_d;
         outstanding_q <= outstanding_d;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         mem[wr_ptr_q[PTR_W-1:0]] <= {aw_id, aw_user, aw_len, aw_err};
      end
   end

   assign b_valid     = b_valid_q;
   assign b_resp      = b_resp_q;
   assign b_id        = b_id_q;
   assign b_user      = b_user_q;
   assign outstanding = outstanding_q;

endmodule

// File: tb/tb_axi4_wresp_gen.sv
// Directed bench for axi4_wresp_gen: handshakes, response codes, ordering,
// back-pressure, back-to-back bursts and mid-burst reset.
module tb_axi4_wresp_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       aw_valid, aw_ready, aw_user, aw_err;
   logic [4:0] aw_id;
   logic [7:0] aw_len;
   logic       w_valid, w_ready, w_last;
   logic       b_valid, b_ready, b_user;
   logic [1:0] b_resp;
   logic [4:0] b_id;
   logic [2:0] outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   axi4_wresp_gen #(.ID_W(5), .AW_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .aw_valid    (aw_valid),
      .aw_ready    (aw_ready),
      .aw_id       (aw_id),
      .aw_user     (aw_user),
      .aw_len      (aw_len),
      .aw_err      (aw_err),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_last      (w_last),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_resp      (b_resp),
      .b_id        (b_id),
      .b_user      (b_user),
      .outstanding (outstanding)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic aw_send(input logic [4:0] id, input logic [7:0] len, input logic err,
                          input logic user);
      @(negedge clk);
      aw_valid = 1'b1; aw_id = id; aw_len = len; aw_err = err; aw_user = user;
      #1;
      for (int i = 0; i < 50 && !aw_ready; i++) begin
         @(negedge clk); #1;
      end
      if (!aw_ready) check("aw_ready_timeout", aw_ready, 1);
      else begin
         @(posedge clk); #1;
      end
      aw_valid = 1'b0;
   endtask

   task automatic w_beat(input logic last);
      @(negedge clk);
      w_valid = 1'b1; w_last = last;
      #1;
      for (int i = 0; i < 50 && !w_ready; i++) begin
         @(negedge clk); #1;
      end
      if (!w_ready) check("w_ready_timeout", w_ready, 1);
      else begin
         @(posedge clk); #1;
      end
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic b_take(input string tag, input logic [4:0] id, input logic [1:0] resp);
      @(negedge clk);
      for (int i = 0; i < 50 && !b_valid; i++) @(negedge clk);
      check({tag, "_valid"}, b_valid, 1);
      check({tag, "_id"}, b_id, id);
      check({tag, "_resp"}, b_resp, resp);
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; aw_valid = 1'b0; aw_id = '0; aw_user = 1'b0; aw_len = '0; aw_err = 1'b0;
      w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_aw_ready", aw_ready, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_b_resp", b_resp, 0);
      check("rst_b_id", b_id, 0);
      check("rst_b_user", b_user, 0);
      check("rst_outstanding", outstanding, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_aw_ready", aw_ready, 1);
      check("post_rst_w_ready", w_ready, 0);

      // Exact-length burst, id 5, user 1
      aw_send(5'd5, 8'd3, 1'b0, 1'b1);
      check("t1_out_after_aw", outstanding, 1);
      w_beat(1'b0); w_beat(1'b0); w_beat(1'b0);
      check("t1_no_b_yet", b_valid, 0);
      w_beat(1'b1);
      check("t1_b_valid_lat1", b_valid, 1);
      check("t1_b_id", b_id, 5);
      check("t1_b_resp", b_resp, 2'b00);
      check("t1_b_user", b_user, 1);
      @(negedge clk); @(negedge clk);
      check("t1_b_held", b_valid, 1);
      check("t1_id_held", b_id, 5);
      b_take("t1", 5'd5, 2'b00);
      check("t1_out_after_b", outstanding, 0);
      check("t1_b_cleared", b_valid, 0);

      // Short burst -> 10, then single-beat burst -> 00
      aw_send(5'd2, 8'd3, 1'b0, 1'b0);
      w_beat(1'b0); w_beat(1'b1);
      b_take("t2_short", 5'd2, 2'b10);
      aw_send(5'd3, 8'd0, 1'b0, 1'b0);
      w_beat(1'b1);
      b_take("t2_single", 5'd3, 2'b00);

      // Decode error
      aw_send(5'd7, 8'd0, 1'b1, 1'b0);
      w_beat(1'b1);
      b_take("t3_err", 5'd7, 2'b11);

      // Back-pressure: fill the FIFO, stall B, check ordering
      for (int k = 1; k <= 4; k++) aw_send(5'(k), 8'd0, 1'b0, 1'b0);
      check("t4_full_aw_ready", aw_ready, 0);
      check("t4_out_4", outstanding, 4);
      w_beat(1'b1);
      check("t4_b1_valid", b_valid, 1);
      check("t4_b1_id", b_id, 1);
      check("t4_aw_reopen", aw_ready, 1);
      aw_send(5'd5, 8'd0, 1'b0, 1'b0);
      check("t4_full_again", aw_ready, 0);
      check("t4_out_max", outstanding, 5);
      @(negedge clk); @(negedge clk);
      check("t4_b1_held", b_valid, 1);
      check("t4_b1_id_held", b_id, 1);
      check("t4_w_blocked", w_ready, 0);
      b_take("t4_b1", 5'd1, 2'b00);
      for (int k = 2; k <= 5; k++) begin
         w_beat(1'b1);
         b_take("t4_order", 5'(k), 2'b00);
      end
      check("t4_out_drained", outstanding, 0);

      // Back-to-back single-beat bursts with b_ready held high
      b_ready = 1'b1;
      for (int k = 10; k <= 13; k++) aw_send(5'(k), 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      w_valid = 1'b1; w_last = 1'b1;
      for (int k = 10; k <= 13; k++) begin
         @(posedge clk); #1;
         check("t5_b_valid", b_valid, 1);
         check("t5_b_id", b_id, 5'(k));
      end
      w_valid = 1'b0; w_last = 1'b0;
      check("t5_out_tail", outstanding, 1);
      @(posedge clk); #1;
      check("t5_b_done", b_valid, 0);
      check("t5_out_zero", outstanding, 0);

      // AW and W together into an empty FIFO: only AW is taken
      @(negedge clk);
      aw_valid = 1'b1; aw_id = 5'd20; aw_len = 8'd0; aw_err = 1'b0;
      w_valid = 1'b1; w_last = 1'b1;
      #1;
      check("t6_w_no_bypass", w_ready, 0);
      check("t6_aw_ready", aw_ready, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      check("t6_no_b_yet", b_valid, 0);
      check("t6_out_1", outstanding, 1);
      @(posedge clk); #1;
      w_valid = 1'b0; w_last = 1'b0;
      check("t6_b_valid", b_valid, 1);
      check("t6_b_id", b_id, 20);
      @(posedge clk); #1;
      check("t6_b_done", b_valid, 0);
      check("t6_out_0", outstanding, 0);
      b_ready = 1'b0;

      // Reset mid-burst discards the burst and the partial beat count
      aw_send(5'd9, 8'd3, 1'b0, 1'b0);
      w_beat(1'b0); w_beat(1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("t7_rst_b_valid", b_valid, 0);
      check("t7_rst_out", outstanding, 0);
      check("t7_rst_aw_ready", aw_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t7_w_empty", w_ready, 0);
      aw_send(5'd4, 8'd3, 1'b0, 1'b0);
      w_beat(1'b0); w_beat(1'b0); w_beat(1'b0); w_beat(1'b1);
      b_take("t7_fresh", 5'd4, 2'b00);
      check("t7_out_end", outstanding, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
